mem_march_bist: RTL and testbench



---
 rtl/mem_march_bist_if.sv | 22 ++
 rtl/mem_march_bist.sv | 231 +++++++++++++++++++++++
 tb/tb_mem_march_bist.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_march_bist_if.sv
// Memory-side bus of the March C- BIST: one write port and one registered read port.
interface mem_march_bist_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
);
    logic                  w_en;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH-1:0] w_data;
    logic                  r_en;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_data;

    modport master (
        output w_en, w_addr, w_data, r_en, r_addr,
        input  r_data
    );

    modport slave (
        input  w_en, w_addr, w_data, r_en, r_addr,
        output r_data
    );
endinterface

// File: rtl/mem_march_bist.sv
// March C- BIST controller: walks the register-file memory through E0..E5,
// compares every read one cycle later and records the first failure.
module mem_march_bist #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int DEPTH      = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    mem_march_bist_if.master      mem,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  fail_o,
    output logic [ADDR_WIDTH-1:0] fail_addr_o,
    output logic [2:0]            fail_elem_o,
    output logic [7:0]            err_count_o
);
    typedef enum logic [3:0] {
        IDLE,
        E0,
        E1,
        E2,
        E3,
        E4,
        E5,
        DRAIN,
        DONE_ST
    } state_t;

    localparam logic [DATA_WIDTH-1:0] B0        = '0;
    localparam logic [DATA_WIDTH-1:0] B1        = '1;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);

    state_t                state_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  phase_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  fail_q;
    logic [ADDR_WIDTH-1:0] fail_addr_q;
    logic [2:0]            fail_elem_q;
    logic [7:0]            err_count_q;
    logic                  cmp_valid_q;
    logic [DATA_WIDTH-1:0] exp_q;
    logic [ADDR_WIDTH-1:0] cmp_addr_q;
    logic [2:0]            cmp_elem_q;

    logic                  rd_en;
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [DATA_WIDTH-1:0] exp_data;
    logic [2:0]            elem;
    logic                  descending;
    logic                  single_op;
    logic                  elem_end;
    logic                  step_end;
    logic [ADDR_WIDTH-1:0] addr_d;
    logic                  mismatch;

    // Read/write elements use phase_q: 0 = read cycle, 1 = write cycle at the same address.
    always_comb begin
        rd_en      = 1'b0;
        wr_en      = 1'b0;
        wr_data    = B0;
        exp_data   = B0;
        elem       = 3'd0;
        descending = 1'b0;
        single_op  = 1'b0;
        unique case (state_q)
            E0: begin
                wr_en     = 1'b1;
                single_op = 1'b1;
            end
            E1: begin
                rd_en    = ~phase_q;
                wr_en    = phase_q;
                exp_data = B0;
                wr_data  = B1;
                elem     = 3'd1;
            end
            E2: begin
                rd_en    = ~phase_q;
                wr_en    = phase_q;
                exp_data = B1;
                wr_data  = B0;
                elem     = 3'd2;
            end
            E3: begin
                rd_en      = ~phase_q;
                wr_en      = phase_q;
                exp_data   = B0;
                wr_data    = B1;
                elem       = 3'd3;
                descending = 1'b1;
            end
            E4: begin
                rd_en      = ~phase_q;
                wr_en      = phase_q;
                exp_data   = B1;
                wr_data    = B0;
                elem       = 3'd4;
                descending = 1'b1;
            end
            E5: begin
                rd_en     = 1'b1;
                exp_data  = B0;
                elem      = 3'd5;
                single_op = 1'b1;
            end
            default: begin
            end
        endcase
        elem_end = descending ? (addr_q == '0) : (addr_q == LAST_ADDR);
        step_end = single_op | phase_q;
        addr_d   = descending ? (addr_q - ADDR_ONE) : (addr_q + ADDR_ONE);
        mismatch = cmp_valid_q && (mem.r_data != exp_q);
    end

    assign mem.w_en    = wr_en;
    assign mem.w_addr  = addr_q;
    assign mem.w_data  = wr_data;
    assign mem.r_en    = rd_en;
    assign mem.r_addr  = addr_q;

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign fail_o      = fail_q;
    assign fail_addr_o = fail_addr_q;
    assign fail_elem_o = fail_elem_q;
    assign err_count_o = err_count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            phase_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            fail_q      <= 1'b0;
            fail_addr_q <= '0;
            fail_elem_q <= '0;
            err_count_q <= '0;
            cmp_valid_q <= 1'b0;
            exp_q       <= '0;
            cmp_addr_q  <= '0;
            cmp_elem_q  <= '0;
        end else begin
            // Read context travels one cycle behind the read so it lines up with r_data.
            cmp_valid_q <= rd_en;
            if (rd_en) begin
                exp_q      <= exp_data;
                cmp_addr_q <= addr_q;
                cmp_elem_q <= elem;
            end

            if (mismatch) begin
                fail_q <= 1'b1;
                if (err_count_q != 8'hFF) begin
                    err_count_q <= err_count_q + 8'd1;
                end
                if (!fail_q) begin
                    fail_addr_q <= cmp_addr_q;
                    fail_elem_q <= cmp_elem_q;
                end
            end

            unique case (state_q)
                IDLE, DONE_ST: begin
                    if (start_i) begin
                        state_q     <= E0;
                        addr_q      <= '0;
                        phase_q     <= 1'b0;
                        busy_q      <= 1'b1;
                        done_q      <= 1'b0;
                        fail_q      <= 1'b0;
                        fail_addr_q <= '0;
                        fail_elem_q <= '0;
                        err_count_q <= '0;
                    end
                end
                E0, E1, E2, E3, E4, E5: begin
                    if (!step_end) begin
                        phase_q <= 1'b1;
                    end else begin
                        phase_q <= 1'b0;
                        if (!elem_end) begin
                            addr_q <= addr_d;
                        end else begin
                            // Hand over straight to the first address of the next element.
                            unique case (state_q)
                                E0: begin
                                    state_q <= E1;
                                    addr_q  <= '0;
                                end
                                E1: begin
                                    state_q <= E2;
                                    addr_q  <= '0;
                                end
                                E2: begin
                                    state_q <= E3;
                                    addr_q  <= LAST_ADDR;
                                end
                                E3: begin
                                    state_q <= E4;
                                    addr_q  <= LAST_ADDR;
                                end
                                E4: begin
                                    state_q <= E5;
                                    addr_q  <= '0;
                                end
                                default: begin
                                    state_q <= DRAIN;
                                end
                            endcase
                        end
                    end
                end
                DRAIN: begin
                    state_q <= DONE_ST;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_march_bist.sv
// Directed bench for mem_march_bist: behavioural register-file memory with
// injectable stuck-at and address-decoder faults, checked against hand-derived results.
module tb_mem_march_bist;
    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 10;
    localparam int OPS   = 10 * DEPTH;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           start;
    logic           busy;
    logic           done;
    logic           fail;
    logic [AW-1:0]  failAddr;
    logic [2:0]     failElem;
    logic [7:0]     errCount;

    int vectors     = 0;
    int miscompares = 0;

    logic [DW-1:0]  memArray [0:15];
    logic           stuckEn   = 1'b0;
    int             aliasMode = 0;

    logic           expWe   [OPS];
    logic [AW-1:0]  expAddr [OPS];
    logic [DW-1:0]  expData [OPS];

    mem_march_bist_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) memIf ();

    mem_march_bist #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start),
        .mem         (memIf),
        .busy_o      (busy),
        .done_o      (done),
        .fail_o      (fail),
        .fail_addr_o (failAddr),
        .fail_elem_o (failElem),
        .err_count_o (errCount)
    );

    always #5 clk = ~clk;

    // aliasMode 1: writes to 2 also land at 5. aliasMode 2: 2 and 5 alias both ways.
    always @(posedge clk) begin
        if (memIf.w_en) begin
            memArray[memIf.w_addr] <= memIf.w_data;
            if (aliasMode >= 1 && memIf.w_addr == 4'd2) memArray[5] <= memIf.w_data;
            if (aliasMode == 2 && memIf.w_addr == 4'd5) memArray[2] <= memIf.w_data;
        end
        if (memIf.r_en) begin
            if (stuckEn && memIf.r_addr == 4'd6) memIf.r_data <= memArray[6] | 8'h08;
            else memIf.r_data <= memArray[memIf.r_addr];
        end
    end

    function automatic logic [35:0] outputsWord();
        return {busy, done, fail, failAddr, failElem, errCount,
                memIf.w_en, memIf.r_en, memIf.w_addr, memIf.r_addr, memIf.w_data};
    endfunction

    task automatic buildTrace();
        int idx = 0;
        int a;
        for (int e = 0; e < 6; e++) begin
            for (int i = 0; i < DEPTH; i++) begin
                a = (e == 3 || e == 4) ? DEPTH - 1 - i : i;
                if (e != 0) begin
                    expWe[idx] = 1'b0; expAddr[idx] = AW'(a); expData[idx] = 8'h00; idx++;
                end
                if (e != 5) begin
                    expWe[idx] = 1'b1; expAddr[idx] = AW'(a);
                    expData[idx] = (e == 1 || e == 3) ? 8'hFF : 8'h00;
                    idx++;
                end
            end
        end
    endtask

    task automatic runMarch(input bit checkTrace, input bit pulseMid);
        int writes = 0;
        int reads  = 0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        vectors++;
        if ({busy, done, fail, failAddr, failElem, errCount} !== {1'b1, 1'b0, 1'b0, 4'd0, 3'd0, 8'd0}) begin
            miscompares++;
            $display("[TB] FAIL start_clear: got busy/done/fail/addr/elem/err=%b/%b/%b/%0d/%0d/%0d, want 1/0/0/0/0/0",
                     busy, done, fail, failAddr, failElem, errCount);
        end
        for (int k = 0; k < OPS; k++) begin
            if (memIf.w_en === 1'b1) writes++;
            if (memIf.r_en === 1'b1) reads++;
            if (checkTrace) begin
                vectors++;
                if (expWe[k]) begin
                    if ({memIf.w_en, memIf.r_en, memIf.w_addr, memIf.w_data} !== {2'b10, expAddr[k], expData[k]}) begin
                        miscompares++;
                        $display("[TB] FAIL trace[%0d]: got we=%b re=%b addr=%0d data=%h, want write addr=%0d data=%h",
                                 k, memIf.w_en, memIf.r_en, memIf.w_addr, memIf.w_data, expAddr[k], expData[k]);
                    end
                end else begin
                    if ({memIf.w_en, memIf.r_en, memIf.r_addr} !== {2'b01, expAddr[k]}) begin
                        miscompares++;
                        $display("[TB] FAIL trace[%0d]: got we=%b re=%b addr=%0d, want read addr=%0d",
                                 k, memIf.w_en, memIf.r_en, memIf.r_addr, expAddr[k]);
                    end
                end
            end
            start = (pulseMid && k == 40);
            @(posedge clk); #1;
        end
        start = 1'b0;
        vectors++;
        if ({busy, done, memIf.w_en, memIf.r_en} !== 4'b1000) begin
            miscompares++;
            $display("[TB] FAIL drain: got busy/done/we/re=%b%b%b%b, want 1000",
                     busy, done, memIf.w_en, memIf.r_en);
        end
        @(posedge clk); #1;
        vectors++;
        if ({busy, done} !== 2'b01) begin
            miscompares++;
            $display("[TB] FAIL done_timing: got busy/done=%b%b, want 01", busy, done);
        end
        if (checkTrace) begin
            vectors++;
            if (writes != 50 || reads != 50) begin
                miscompares++;
                $display("[TB] FAIL op_count: got writes=%0d reads=%0d, want 50/50", writes, reads);
            end
        end
    endtask

    task automatic checkResults(input string name, input logic wFail, input logic [AW-1:0] wAddr,
                                input logic [2:0] wElem, input logic [7:0] wErr);
        vectors++;
        if (fail !== wFail) begin
            miscompares++;
            $display("[TB] FAIL %s fail: got %b, want %b", name, fail, wFail);
        end
        vectors++;
        if (failAddr !== wAddr) begin
            miscompares++;
            $display("[TB] FAIL %s fail_addr: got %0d, want %0d", name, failAddr, wAddr);
        end
        vectors++;
        if (failElem !== wElem) begin
            miscompares++;
            $display("[TB] FAIL %s fail_elem: got %0d, want %0d", name, failElem, wElem);
        end
        vectors++;
        if (errCount !== wErr) begin
            miscompares++;
            $display("[TB] FAIL %s err_count: got %0d, want %0d", name, errCount, wErr);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (outputsWord() !== 36'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_state: got %h, want 0", outputsWord());
        end
        rst_n = 1'b1;
    endtask

    task automatic test_clean_run();
        runMarch(1'b1, 1'b0);
        checkResults("clean", 1'b0, 4'd0, 3'd0, 8'd0);
    endtask

    task automatic test_stuck_fault();
        stuckEn = 1'b1;
        runMarch(1'b0, 1'b0);
        checkResults("stuck", 1'b1, 4'd6, 3'd1, 8'd3);
    endtask

    task automatic test_back_to_back();
        stuckEn = 1'b0;
        runMarch(1'b1, 1'b0);
        checkResults("b2b", 1'b0, 4'd0, 3'd0, 8'd0);
    endtask

    // One-way coupling is caught only in E1 and E2; the symmetric alias also in E3 and E4.
    task automatic test_addr_fault();
        aliasMode = 1;
        runMarch(1'b0, 1'b0);
        checkResults("alias_oneway", 1'b1, 4'd5, 3'd1, 8'd2);
        aliasMode = 2;
        runMarch(1'b0, 1'b0);
        checkResults("alias_both", 1'b1, 4'd5, 3'd1, 8'd4);
        aliasMode = 0;
    endtask

    task automatic test_start_ignored();
        stuckEn = 1'b1;
        runMarch(1'b0, 1'b1);
        checkResults("start_busy", 1'b1, 4'd6, 3'd1, 8'd3);
        stuckEn = 1'b0;
    endtask

    task automatic test_reset_mid();
        stuckEn = 1'b1;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        vectors++;
        if ({busy, fail, errCount} !== {1'b1, 1'b1, 8'd1}) begin
            miscompares++;
            $display("[TB] FAIL mid_run_state: got busy/fail/err=%b/%b/%0d, want 1/1/1", busy, fail, errCount);
        end
        #1 rst_n = 1'b0;
        #1;
        vectors++;
        if (outputsWord() !== 36'd0) begin
            miscompares++;
            $display("[TB] FAIL async_reset: got %h, want 0", outputsWord());
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        stuckEn = 1'b0;
        @(posedge clk); #1;
        vectors++;
        if (outputsWord() !== 36'd0) begin
            miscompares++;
            $display("[TB] FAIL idle_after_reset: got %h, want 0", outputsWord());
        end
        runMarch(1'b1, 1'b0);
        checkResults("restart", 1'b0, 4'd0, 3'd0, 8'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int i = 0; i < 16; i++) memArray[i] = 8'h5A;
        buildTrace();
        test_reset();
        test_clean_run();
        test_stuck_fault();
        test_back_to_back();
        test_addr_fault();
        test_start_ignored();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
